alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have one clock and reset: clk input 1, the single clock; rst_n input 1, reset, synchronous and active-low.
REQ-002 req_valid input 1: a request is present.
REQ-003 req_ready output 1: the block can accept a request.
REQ-004 req_op input 4: ALU opcode, same encoding as the 8051 ALU.
REQ-005 req_wide input 1: two-pass 16-bit add/sub.
REQ-006 req_a input 16 and req_b input 16: operands.
REQ-007 req_c input 8: third operand for opcodes 1110/1111.
REQ-008 req_cy_in input 1: explicit carry-in.
REQ-009 use_psw_cy input 1: when 1, psw_cy is the carry-in instead of req_cy_in.
REQ-010 alu_src1, alu_src2, alu_src3 outputs 8 each, alu_opcode output 4, alu_p_cy output 1: drive the external combinational ALU.
REQ-011 alu_dest input 16, alu_cy input 1, alu_ox input 1, alu_ovf input 1: ALU results.
REQ-012 rsp_valid output 1, rsp_ready input 1, rsp_data output 16, rsp_err output 1: response channel.
REQ-013 psw_cy, psw_ac, psw_ov outputs 1 each: registered flags.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC_LO, EXEC_HI and RESP.
- req_ready=1 only in IDLE.
- Accept on req_valid & req_ready and latch all req_* fields, including the chosen carry-in.
REQ-015 Transitions SHALL be:
- IDLE to EXEC_LO on accept.
- EXEC_LO to EXEC_HI if the request is wide-legal, else to RESP.
- EXEC_HI to RESP.
- RESP to IDLE on rsp_valid & rsp_ready.
REQ-016 Wide-legal SHALL mean req_wide=1 and req_op is 0001 or 0010; req_wide=1 with any other opcode executes narrow.
REQ-017 ALU outputs SHALL be driven from latched fields only in EXEC_LO and EXEC_HI; alu_opcode=0000 and all other ALU outputs are 0 elsewhere.
REQ-018 In EXEC_LO, operand routing SHALL be:
- opcodes 1110/1111: src1=a[15:8], src2=a[7:0], src3=c.
- all other opcodes: src1=a[7:0], src2=b[7:0], src3=c.
- alu_p_cy = the latched carry-in.
REQ-019 In EXEC_HI: src1=a[15:8], src2=b[15:8], alu_p_cy = alu_cy captured at the end of EXEC_LO.
REQ-020 Result capture SHALL be:
- alu_dest is captured at the end of each EXEC state.
- Narrow: rsp_data = captured alu_dest[15:0].
- Wide: rsp_data = {hi dest[7:0], lo dest[7:0]}.
REQ-021 Latency SHALL be: narrow rsp_valid 2 cycles after the accept edge; wide 3 cycles after.
REQ-022 rsp_valid, rsp_data and rsp_err SHALL hold stable in RESP until rsp_ready; the next accept is possible no earlier than the cycle after the response handshake.
REQ-023 Flags SHALL update at the end of the final EXEC state:
- 0001/0010/0101: psw_cy=alu_cy, psw_ac=alu_ox, psw_ov=alu_ovf. For wide requests, psw_ac comes from the low pass and psw_cy/psw_ov from the high pass.
- 0011/0100: psw_cy=0, psw_ov=alu_ovf, psw_ac unchanged.
- 1011/1101: psw_cy=alu_cy only.
- All other opcodes: flags unchanged.
REQ-024 Opcode 0000 SHALL skip ALU capture, return rsp_data=0 and rsp_err=1, and leave flags unchanged.
REQ-025 Opcode 0100 with alu_ovf=1 SHALL return rsp_err=1 and rsp_data=0.
REQ-026 rsp_err SHALL be 0 in all other cases.
REQ-027 The carry-in SHALL be sampled from psw_cy at accept, so back-to-back chained requests see the prior result's carry.

Reset
REQ-028 When rst_n=0 at a clk edge, the block SHALL go to IDLE with: req_ready=1 after reset; rsp_valid=0, rsp_data=0, rsp_err=0; psw_cy=psw_ac=psw_ov=0; latched fields 0.
REQ-029 A reset during EXEC_LO, EXEC_HI or RESP SHALL discard the operation with no response and no flag update.

Structure
REQ-030 Shared package alu_seq_pkg SHALL hold the 4-bit opcode constants and the state enum, and be reused by the ALU and decoder.
REQ-031 One combinational sub-module, alu_flag_dec, SHALL map opcode and pass to flag-update enables; the ALU itself remains external.

Verification
REQ-032 Narrow ADD: op=0001, a=0x003A, b=0x00C8, cy_in=0, use_psw_cy=0 -> rsp_data=0x0002, psw_cy=1, psw_ac=1, rsp_valid 2 cycles after accept.
REQ-033 Wide ADD: op=0001, wide=1, a=0x12FF, b=0x0001 -> hi pass alu_p_cy=1, rsp_data=0x1300, psw_cy=0, rsp_valid 3 cycles after accept.
REQ-034 DIV by zero: op=0100, a=0x0010, b=0 -> rsp_err=1, rsp_data=0, psw_ov=1, psw_cy=0.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready=0 throughout; handshake in cycle 6 -> req_ready=1 the next cycle.
REQ-036 Reset mid-op: rst_n=0 during EXEC_HI of a wide add -> next state IDLE, no response, flags 0.
REQ-037 Chained carry: an add leaving psw_cy=1, then op=0001 with use_psw_cy=1, a=0x0001, b=0x0001 -> rsp_data=0x0003.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: 8051 ALU opcodes, sequencer
// states and the flag-update enable bundle.
package alu_seq_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_DA  = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_RL  = 4'b1010;
  localparam logic [3:0] OP_RLC = 4'b1011;
  localparam logic [3:0] OP_RR  = 4'b1100;
  localparam logic [3:0] OP_RRC = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_XCH = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_EXEC_LO = 2'b01,
    ST_EXEC_HI = 2'b10,
    ST_RESP    = 2'b11
  } seq_state_e;

  typedef struct packed {
    logic upd_cy;
    logic clr_cy;
    logic upd_ac;
    logic ac_from_lo;
    logic upd_ov;
  } flag_en_t;

  // Only add/sub can be chained through the carry for a 16-bit result.
  function automatic logic is_wide_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic uses_a_pair(input logic [3:0] op);
    return (op == OP_PCS) || (op == OP_XCH);
  endfunction

endpackage

// File: rtl/alu_flag_dec.sv
// Maps opcode and execution pass to PSW flag-update enables; enables are
// only raised on the final pass of a request.
module alu_flag_dec
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  input  logic       pass_hi,
  input  logic       last_pass,
  output flag_en_t   flag_en
);

  always_comb begin
    flag_en = '0;
    if (last_pass) begin
      case (op)
        OP_ADD, OP_SUB, OP_DA: begin
          flag_en.upd_cy     = 1'b1;
          flag_en.upd_ac     = 1'b1;
          flag_en.upd_ov     = 1'b1;
          // Half carry of a 16-bit add/sub belongs to the low byte.
          flag_en.ac_from_lo = pass_hi;
        end
        OP_MUL, OP_DIV: begin
          flag_en.upd_cy = 1'b1;
          flag_en.clr_cy = 1'b1;
          flag_en.upd_ov = 1'b1;
        end
        OP_RLC, OP_RRC: begin
          flag_en.upd_cy = 1'b1;
        end
        default: flag_en = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response sequencer around an external 8051-style combinational
// ALU, with optional two-pass 16-bit add/sub and registered PSW flags.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | ready for a request; ALU inputs held at zero
// ST_EXEC_LO | low (or only) pass on the ALU
// ST_EXEC_HI | high byte pass of a wide add/sub, carry from low pass
// ST_RESP    | response presented, waiting for rsp_ready
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic        req_wide,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [7:0]  req_c,
  input  logic        req_cy_in,
  input  logic        use_psw_cy,

  output logic [7:0]  alu_src1,
  output logic [7:0]  alu_src2,
  output logic [7:0]  alu_src3,
  output logic [3:0]  alu_opcode,
  output logic        alu_p_cy,
  input  logic [15:0] alu_dest,
  input  logic        alu_cy,
  input  logic        alu_ox,
  input  logic        alu_ovf,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,

  output logic        psw_cy,
  output logic        psw_ac,
  output logic        psw_ov
);

  seq_state_e state;

  logic [3:0]  op_q;
  logic        wide_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [7:0]  c_q;
  logic        cy_q;

  logic [7:0]  lo_dest_q;
  logic        lo_cy_q;
  logic        lo_ox_q;

  logic        wide_legal;
  logic        pass_hi;
  logic        last_pass;
  logic        res_err;
  logic [15:0] res_data;
  logic        ac_src;
  flag_en_t    flag_en;

  assign req_ready  = (state == ST_IDLE);
  assign rsp_valid  = (state == ST_RESP);
  assign wide_legal = wide_q && is_wide_op(op_q);
  assign pass_hi    = (state == ST_EXEC_HI);
  assign last_pass  = pass_hi || ((state == ST_EXEC_LO) && !wide_legal);

  always_comb begin
    alu_opcode = OP_NOP;
    alu_src1   = 8'h00;
    alu_src2   = 8'h00;
    alu_src3   = 8'h00;
    alu_p_cy   = 1'b0;
    case (state)
      ST_EXEC_LO: begin
        alu_opcode = op_q;
        alu_src3   = c_q;
        alu_p_cy   = cy_q;
        if (uses_a_pair(op_q)) begin
          alu_src1 = a_q[15:8];
          alu_src2 = a_q[7:0];
        end else begin
          alu_src1 = a_q[7:0];
          alu_src2 = b_q[7:0];
        end
      end
      ST_EXEC_HI: begin
        alu_opcode = op_q;
        alu_src1   = a_q[15:8];
        alu_src2   = b_q[15:8];
        alu_src3   = c_q;
        alu_p_cy   = lo_cy_q;
      end
      default: ;
    endcase
  end

  alu_flag_dec u_flag_dec (
    .op        (op_q),
    .pass_hi   (pass_hi),
    .last_pass (last_pass),
    .flag_en   (flag_en)
  );

  // Errors force a zero payload so a consumer never sees stale ALU data.
  assign res_err  = (op_q == OP_NOP) || ((op_q == OP_DIV) && alu_ovf);
  assign res_data = res_err ? 16'h0000
                  : (pass_hi ? {alu_dest[7:0], lo_dest_q} : alu_dest);
  assign ac_src   = flag_en.ac_from_lo ? lo_ox_q : alu_ox;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= 4'h0;
      wide_q    <= 1'b0;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      c_q       <= 8'h00;
      cy_q      <= 1'b0;
      lo_dest_q <= 8'h00;
      lo_cy_q   <= 1'b0;
      lo_ox_q   <= 1'b0;
      rsp_data  <= 16'h0000;
      rsp_err   <= 1'b0;
      psw_cy    <= 1'b0;
      psw_ac    <= 1'b0;
      psw_ov    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            wide_q <= req_wide;
            a_q    <= req_a;
            b_q    <= req_b;
            c_q    <= req_c;
            cy_q   <= use_psw_cy ? psw_cy : req_cy_in;
            state  <= ST_EXEC_LO;
          end
        end
        ST_EXEC_LO: begin
          if (op_q != OP_NOP) begin
            lo_dest_q <= alu_dest[7:0];
            lo_cy_q   <= alu_cy;
            lo_ox_q   <= alu_ox;
          end
          state <= wide_legal ? ST_EXEC_HI : ST_RESP;
        end
        ST_EXEC_HI: state <= ST_RESP;
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (last_pass) begin
        rsp_data <= res_data;
        rsp_err  <= res_err;
      end
      if (flag_en.upd_cy) psw_cy <= flag_en.clr_cy ? 1'b0 : alu_cy;
      if (flag_en.upd_ac) psw_ac <= ac_src;
      if (flag_en.upd_ov) psw_ov <= alu_ovf;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a small behavioural model of
// the external 8051 ALU and hand-computed expected results.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wide, req_cy_in, use_psw_cy;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b;
  logic [7:0]  req_c;
  logic [7:0]  alu_src1, alu_src2, alu_src3;
  logic [3:0]  alu_opcode;
  logic        alu_p_cy;
  logic [15:0] alu_dest;
  logic        alu_cy, alu_ox, alu_ovf;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data;
  logic        psw_cy, psw_ac, psw_ov;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_wide(req_wide), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .req_cy_in(req_cy_in), .use_psw_cy(use_psw_cy),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_src3(alu_src3),
    .alu_opcode(alu_opcode), .alu_p_cy(alu_p_cy),
    .alu_dest(alu_dest), .alu_cy(alu_cy), .alu_ox(alu_ox), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .psw_cy(psw_cy), .psw_ac(psw_ac), .psw_ov(psw_ov)
  );

  // Behavioural stand-in for the external combinational ALU
  logic [8:0]  t9;
  logic [15:0] p16;
  always_comb begin
    alu_dest = 16'h0000;
    alu_cy   = 1'b0;
    alu_ox   = 1'b0;
    alu_ovf  = 1'b0;
    t9       = 9'h000;
    p16      = 16'h0000;
    case (alu_opcode)
      4'b0001: begin
        t9       = {1'b0, alu_src1} + {1'b0, alu_src2} + {8'h00, alu_p_cy};
        alu_dest = {8'h00, t9[7:0]};
        alu_cy   = t9[8];
        alu_ox   = ({1'b0, alu_src1[3:0]} + {1'b0, alu_src2[3:0]} + {4'h0, alu_p_cy}) > 5'd15;
        alu_ovf  = (alu_src1[7] == alu_src2[7]) && (t9[7] != alu_src1[7]);
      end
      4'b0010: begin
        t9       = {1'b0, alu_src1} - {1'b0, alu_src2} - {8'h00, alu_p_cy};
        alu_dest = {8'h00, t9[7:0]};
        alu_cy   = t9[8];
        alu_ox   = {1'b0, alu_src1[3:0]} < ({1'b0, alu_src2[3:0]} + {4'h0, alu_p_cy});
        alu_ovf  = (alu_src1[7] != alu_src2[7]) && (t9[7] != alu_src1[7]);
      end
      4'b0011: begin
        p16      = {8'h00, alu_src1} * {8'h00, alu_src2};
        alu_dest = p16;
        alu_ovf  = |p16[15:8];
      end
      4'b0100: begin
        if (alu_src2 == 8'h00) alu_ovf = 1'b1;
        else alu_dest = {alu_src1 % alu_src2, alu_src1 / alu_src2};
      end
      4'b0111: alu_dest = {8'h00, alu_src1 & alu_src2};
      4'b1000: alu_dest = {8'h00, alu_src1 ^ alu_src2};
      4'b1001: alu_dest = {8'h00, alu_src1 | alu_src2};
      4'b1011: begin
        alu_dest = {8'h00, alu_src1[6:0], alu_p_cy};
        alu_cy   = alu_src1[7];
      end
      4'b1110: alu_dest = {alu_src1, alu_src2} + {8'h00, alu_src3};
      default: alu_dest = 16'h0000;
    endcase
  end

  typedef struct {
    logic [3:0]  op;
    logic        wide;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  c;
    logic        cy_in;
    logic        use_psw;
    logic [15:0] exp_data;
    logic        exp_err;
    logic        exp_cy;
    logic        exp_ac;
    logic        exp_ov;
    int          exp_lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    req_op     = v.op;
    req_wide   = v.wide;
    req_a      = v.a;
    req_b      = v.b;
    req_c      = v.c;
    req_cy_in  = v.cy_in;
    use_psw_cy = v.use_psw;
    req_valid  = 1'b1;
  endtask

  // Starts at a negedge in IDLE; latency counts the accept cycle as cycle 0.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bit got;
    chk($sformatf("v%0d_req_ready", idx), req_ready, 1);
    drive_req(v);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    got = rsp_valid;
    while (!got && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      got = rsp_valid;
    end
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_data", idx), rsp_data, v.exp_data);
    chk($sformatf("v%0d_err", idx), rsp_err, v.exp_err);
    chk($sformatf("v%0d_psw", idx), {psw_cy, psw_ac, psw_ov},
        {v.exp_cy, v.exp_ac, v.exp_ov});
    @(posedge clk); #1;
    chk($sformatf("v%0d_rsp_done", idx), rsp_valid, 0);
    @(negedge clk);
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, rsp_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    //             op     wd    a         b         c      ci    up    data      er    cy    ac    ov  lat
    vecs[0]  = '{4'h1, 1'b0, 16'h003A, 16'h00C8, 8'h00, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b0, 2};
    vecs[1]  = '{4'h1, 1'b1, 16'h12FF, 16'h0001, 8'h00, 1'b0, 1'b0, 16'h1300, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    vecs[2]  = '{4'h4, 1'b0, 16'h0010, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 2};
    vecs[3]  = '{4'h0, 1'b0, 16'h5555, 16'h1111, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 2};
    vecs[4]  = '{4'h2, 1'b0, 16'h0050, 16'h0070, 8'h00, 1'b1, 1'b0, 16'h00DF, 1'b0, 1'b1, 1'b1, 1'b0, 2};
    vecs[5]  = '{4'h3, 1'b0, 16'h0010, 16'h0020, 8'h00, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b1, 1'b1, 2};
    vecs[6]  = '{4'h7, 1'b0, 16'h00F0, 16'h003C, 8'h00, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b1, 1'b1, 2};
    vecs[7]  = '{4'h8, 1'b1, 16'hFF0F, 16'hFFFF, 8'h00, 1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b1, 1'b1, 2};
    vecs[8]  = '{4'hB, 1'b0, 16'h0081, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b1, 2};
    vecs[9]  = '{4'h1, 1'b0, 16'h0001, 16'h0001, 8'h00, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    vecs[10] = '{4'h2, 1'b1, 16'h1000, 16'h0001, 8'h00, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    vecs[11] = '{4'h4, 1'b0, 16'h0017, 16'h0005, 8'h00, 1'b0, 1'b0, 16'h0304, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    vecs[12] = '{4'h1, 1'b0, 16'h007F, 16'h0001, 8'h00, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b1, 2};
    vecs[13] = '{4'hE, 1'b0, 16'h1234, 16'hABCD, 8'h05, 1'b0, 1'b0, 16'h1239, 1'b0, 1'b0, 1'b1, 1'b1, 2};
    vecs[14] = '{4'h1, 1'b1, 16'h00FF, 16'h00FF, 8'h00, 1'b1, 1'b0, 16'h01FF, 1'b0, 1'b0, 1'b1, 1'b0, 3};

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = 4'h0; req_wide = 1'b0; req_a = 16'h0; req_b = 16'h0; req_c = 8'h0;
    req_cy_in = 1'b0; use_psw_cy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_psw", {psw_cy, psw_ac, psw_ov}, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Operand routing on both passes of a wide add
    t = vecs[1];
    drive_req(t);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wlo_opcode", alu_opcode, 4'h1);
    chk("wlo_srcs", {alu_src1, alu_src2}, 16'hFF01);
    chk("wlo_p_cy", alu_p_cy, 0);
    @(posedge clk); #1;
    chk("whi_srcs", {alu_src1, alu_src2}, 16'h1200);
    chk("whi_p_cy", alu_p_cy, 1);
    @(posedge clk); #1;
    chk("wresp_valid", rsp_valid, 1);
    chk("wresp_data", rsp_data, 16'h1300);
    chk("wresp_alu_idle", {alu_opcode, alu_src1, alu_src2, alu_p_cy}, 0);
    @(posedge clk);
    @(negedge clk);

    // Pair-operand routing for opcode 1110
    t = vecs[13];
    drive_req(t);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pcs_srcs", {alu_src1, alu_src2, alu_src3}, 24'h123405);
    wait_rsp("pcs_rsp");
    @(posedge clk);
    @(negedge clk);

    // Backpressure: five stalled RESP cycles, handshake on the sixth
    rsp_ready = 1'b0;
    t = '{4'h7, 1'b0, 16'h00FF, 16'h003C, 8'h00, 1'b0, 1'b0, 16'h003C, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    drive_req(t);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp("bp_rsp");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_hold", i), {rsp_valid, rsp_data, rsp_err, req_ready}, {1'b1, 16'h003C, 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {req_ready, rsp_valid}, 2'b10);
    @(negedge clk);

    // Reset in EXEC_HI of a wide add drops the operation and clears flags
    t = vecs[1];
    drive_req(t);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_in_hi", alu_p_cy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_req_ready", req_ready, 1);
    chk("mid_rsp", {rsp_valid, rsp_data, rsp_err}, 0);
    chk("mid_psw", {psw_cy, psw_ac, psw_ov}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_quiet%0d", i), rsp_valid, 0);
    end
    @(negedge clk);

    // Chained carry straight after a carry-producing add
    t = '{4'h1, 1'b0, 16'h00FF, 16'h0001, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 2};
    run_vec(t, 100);
    t = '{4'h1, 1'b0, 16'h0001, 16'h0001, 8'h00, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    run_vec(t, 101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
